// File: rtl/mux_test_sequencer.sv
// Exhaustive 64-vector stimulus/checker for the mux4 comparison harness.
// Optional MUX_TEST_SYNC_EN adds 2-flop synchronizers on gf_out/bfg_out and lengthens the dwell.
module mux_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 i0,
  output logic                 i1,
  output logic                 i2,
  output logic                 i3,
  output logic                 s0,
  output logic                 s1,
  input  logic                 gf_out,
  input  logic                 bfg_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 gf_fail,
  output logic                 bfg_fail,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_fail_valid,
  output logic [5:0]           first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

`ifdef MUX_TEST_SYNC_EN
  localparam int DWELL = SETTLE_CYCLES + 2;
`else
  localparam int DWELL = SETTLE_CYCLES;
`endif
  localparam logic [4:0]           DWELL_LD = 5'(DWELL - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [5:0]           vec_q, vec_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 gf_fail_q, gf_fail_d;
  logic                 bfg_fail_q, bfg_fail_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 ffv_q, ffv_d;
  logic [5:0]           ffvec_q, ffvec_d;

  logic gf_smp, bfg_smp;

`ifdef MUX_TEST_SYNC_EN
  logic gf_meta_q, gf_sync_q, bfg_meta_q, bfg_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gf_meta_q  <= 1'b0;
      gf_sync_q  <= 1'b0;
      bfg_meta_q <= 1'b0;
      bfg_sync_q <= 1'b0;
    end else begin
      gf_meta_q  <= gf_out;
      gf_sync_q  <= gf_meta_q;
      bfg_meta_q <= bfg_out;
      bfg_sync_q <= bfg_meta_q;
    end
  end

  assign gf_smp  = gf_sync_q;
  assign bfg_smp = bfg_sync_q;
`else
  assign gf_smp  = gf_out;
  assign bfg_smp = bfg_out;
`endif

  logic [3:0] data_bits;
  logic       exp_bit, gf_mis, bfg_mis;

  assign data_bits = vec_q[3:0];
  assign exp_bit   = data_bits[vec_q[5:4]];
  assign gf_mis    = (gf_smp != exp_bit);
  assign bfg_mis   = (bfg_smp != exp_bit);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    gf_fail_d  = gf_fail_q;
    bfg_fail_d = bfg_fail_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;

    // Abort wins over everything, including a CHECK result on the same edge.
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = SETTLE;
            vec_d      = 6'd0;
            cnt_d      = DWELL_LD;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            gf_fail_d  = 1'b0;
            bfg_fail_d = 1'b0;
            err_d      = '0;
            ffv_d      = 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == 5'd0) state_d = CHECK;
          else               cnt_d   = cnt_q - 5'd1;
        end
        CHECK: begin
          if (gf_mis)  gf_fail_d  = 1'b1;
          if (bfg_mis) bfg_fail_d = 1'b1;
          if (gf_mis || bfg_mis) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          if (vec_q == 6'd63) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SETTLE;
            vec_d   = vec_q + 6'd1;
            cnt_d   = DWELL_LD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 6'd0;
      cnt_q      <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gf_fail_q  <= 1'b0;
      bfg_fail_q <= 1'b0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gf_fail_q  <= gf_fail_d;
      bfg_fail_q <= bfg_fail_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffvec_q    <= ffvec_d;
    end
  end

  assign {s1, s0, i3, i2, i1, i0} = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign gf_fail          = gf_fail_q;
  assign bfg_fail         = bfg_fail_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign pass             = done_q && (err_q == '0) && !gf_fail_q && !bfg_fail_q;

endmodule
